// File: rtl/dmem_ram_pkg.sv
// Shared defaults and types for the byte-enabled data memory and its read-slot FSM.
package dmem_ram_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 256;
    localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);
    localparam int BE_W_DEF   = DATA_W_DEF / 8;

    typedef logic [DATA_W_DEF-1:0] word_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [BE_W_DEF-1:0]   be_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;
endpackage

// File: rtl/dmem_ram_array.sv
// Word storage with one write strobe per byte lane and an asynchronous read port.
module dmem_ram_array
    import dmem_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [DATA_W/8-1:0]   wr_strb_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_W-1:0]     rd_data_o
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Each lane is written on its own strobe so unselected bytes are never touched.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_strb_i[i]) begin
                mem[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
            end
        end
    end

    assign rd_data_o = mem[rd_addr_i];
endmodule

// File: rtl/dmem_ram.sv
// Data memory top: write gating, read handshake slot, same-edge forwarding and range errors.
module dmem_ram
    import dmem_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  rd_req,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  rd_ready,
    output logic                  err
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    slot_state_e       slot_q;
    logic [DATA_W-1:0] rdData_q, rdData_d;
    logic              err_q, err_d;
    logic              wrInRange, rdInRange, accept;
    logic [NB-1:0]     wrStrb;
    logic [DATA_W-1:0] arrayRdData;

    assign wrInRange = ({1'b0, wr_addr} < DEPTH_L);
    assign rdInRange = ({1'b0, rd_addr} < DEPTH_L);
    assign rd_gnt    = (slot_q == SLOT_EMPTY) || rd_ready;
    assign accept    = rd_req && rd_gnt;
    assign wrStrb    = (wr_en && wrInRange && !rst) ? wr_be : '0;
    assign err_d     = (accept && !rdInRange) || (wr_en && !wrInRange && (|wr_be));

    dmem_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk       (clk),
        .wr_strb_i (wrStrb),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (arrayRdData)
    );

    // A same-address write on the accept edge wins byte-by-byte over stale storage.
    always_comb begin
        rdData_d = '0;
        if (rdInRange) begin
            for (int i = 0; i < NB; i++) begin
                rdData_d[8*i +: 8] = (wrStrb[i] && (wr_addr == rd_addr)) ?
                                     wr_data[8*i +: 8] : arrayRdData[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q   <= SLOT_EMPTY;
            rdData_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= err_d;
            case (slot_q)
                SLOT_EMPTY: begin
                    if (accept) begin
                        slot_q   <= SLOT_FULL;
                        rdData_q <= rdData_d;
                    end
                end
                SLOT_FULL: begin
                    if (accept) begin
                        rdData_q <= rdData_d;
                    end else if (rd_ready) begin
                        slot_q <= SLOT_EMPTY;
                    end
                end
            endcase
        end
    end

    assign rd_valid = (slot_q == SLOT_FULL);
    assign rd_data  = rdData_q;
    assign err      = err_q;
endmodule

// File: doc/dmem_ram.md
DMEM_RAM -- requirements
Module: dmem_ram

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 256, number of words; SHALL be >= 2.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), word-address width.
REQ-004 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port wr_en  input  1  write request, sampled every cycle.
REQ-007 Port wr_addr  input  ADDR_W  word address of the write.
REQ-008 Port wr_data  input  DATA_W  write data.
REQ-009 Port wr_be  input  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i].
REQ-010 Port rd_req  input  1  read request.
REQ-011 Port rd_addr  input  ADDR_W  word address of the read.
REQ-012 Port rd_gnt  output  1  combinational read acceptance.
REQ-013 Port rd_valid  output  1  rd_data holds a completed read.
REQ-014 Port rd_data  output  DATA_W  registered read data.
REQ-015 Port rd_ready  input  1  consumer accepts rd_data this cycle.
REQ-016 Port err  output  1  one-cycle pulse on an out-of-range access.

Function
REQ-017 Write: on an edge with wr_en=1 and wr_addr<DEPTH, each byte with wr_be[i]=1 SHALL be updated; bytes with wr_be[i]=0 SHALL be unchanged.
REQ-018 Write with wr_en=1 and wr_be all zero SHALL change no storage and raise no err.
REQ-019 rd_gnt SHALL equal !rd_valid || rd_ready; a read is accepted on an edge where rd_req && rd_gnt.
REQ-020 Output slot FSM: EMPTY (rd_valid=0) and FULL (rd_valid=1); EMPTY->FULL on accept; FULL->FULL on accept with rd_ready=1; FULL->EMPTY on rd_ready=1 without accept.
REQ-021 Read latency SHALL be exactly one cycle: rd_valid=1 and rd_data valid on the edge after acceptance.
REQ-022 While rd_valid=1 and rd_ready=0, rd_data SHALL be held stable and rd_req SHALL NOT be accepted; the requester holds rd_req/rd_addr.
REQ-023 Read and write to the same in-range address on the same edge: rd_data SHALL be write-first per byte (enabled bytes from wr_data, others from storage).
REQ-024 Out-of-range read (rd_addr>=DEPTH, possible when DEPTH is not a power of 2) SHALL complete normally with rd_data=0 and err=1 on the completion edge.
REQ-025 Out-of-range write SHALL modify no storage and SHALL drive err=1 for the following cycle.
REQ-026 err SHALL be the OR of REQ-024 and REQ-025 conditions; it SHALL be 0 in every other cycle.
REQ-027 Storage SHALL NOT be read-modified-written; byte-enable merging SHALL use per-byte write strobes.

Reset
REQ-028 While rst=1: rd_valid=0, rd_data=0, err=0, FSM=EMPTY, independent of clk.
REQ-029 Storage contents SHALL NOT be reset; writes during rst=1 SHALL be ignored.
REQ-030 A read accepted in the cycle rst asserts SHALL be discarded; no rd_valid after release.

Structure
REQ-031 type_pkg SHALL hold the DATA_W/DEPTH defaults and the typedefs for data word, word address and byte-enable vectors.
REQ-032 Storage SHALL be a sub-module dmem_ram_array (per-byte write strobes, combinational read); handshake, forwarding, err and output register live in dmem_ram.

Verification
REQ-033 Reset, write 0xDEADBEEF to addr 5 with wr_be=0xF, read addr 5 with rd_ready=1 -> rd_valid=1 one cycle after accept, rd_data=0xDEADBEEF, err=0.
REQ-034 Addr 5 holds 0xDEADBEEF, write 0x000000AA wr_be=0x1, then 0x11220000 wr_be=0xC -> read returns 0x1122BEAA.
REQ-035 Same-edge write 0xCAFEF00D wr_be=0x3 and read of addr 7 holding 0x12345678 -> rd_data=0x1234F00D.
REQ-036 Read completes with rd_ready=0 for 3 cycles, rd_req held to another address -> rd_gnt=0, rd_data stable 3 cycles; second read accepted the edge rd_ready=1, result next cycle.
REQ-037 DEPTH=10: write addr 12 then read addr 12 -> err pulses 1 cycle after each, rd_data=0, addresses 0..9 unchanged.
REQ-038 Assert rst the cycle after a read is accepted -> rd_valid=0 and rd_data=0 immediately, no rd_valid after release, storage preserved.
